full_adder: RTL and testbench
=============================

# full_adder

Single-bit full adder built from primitive gates, providing combinational sum and carry of three input bits. It also provides one-cycle registered copies of the result for clocked downstream logic. It is the leaf cell of the ripple-carry adder chains in the datapath. The first five ports keep the legacy positional order (sum, carry, a, b, c), so existing positional instantiations stay valid.

## Interface
- No parameters; the cell is fixed at 1 bit.
- Port declaration order is sum, carry, a, b, c, clk, rst, sum_q, carry_q, err. The list below gives clock and reset first.
- clk  input  1  single clock; all registers are rising-edge.
- rst  input  1  reset, synchronous and active-high.
- sum  output  1  combinational a ^ b ^ c.
- carry  output  1  combinational majority(a, b, c) = (a&b) | (c&(a^b)).
- a  input  1  addend bit.
- b  input  1  addend bit.
- c  input  1  carry-in.
- sum_q  output  1  sum registered on clk.
- carry_q  output  1  carry registered on clk.
- err  output  1  sticky self-check error flag; present only with FULL_ADDER_CHECK_EN.

## Operation
- Truth table, with the result given as {carry,sum}:
  - 000→00, 001→01, 010→01, 011→10
  - 100→01, 101→10, 110→10, 111→11
- The combinational path uses only gate primitives or equivalent continuous logic, composed as:
  - two half adders, ha0(a,b) and ha1(ha0.s, c);
  - carry = ha0.co | ha1.co.
- The combinational path has no dependency on clk or rst. sum and carry are valid whenever a, b and c are driven.
- Any X or Z on an input propagates as X on the outputs; there is no masking.
- Registered path:
  - each rising clk edge loads sum_q ← sum and carry_q ← carry;
  - rst = 1 at an edge overrides the load and forces sum_q = 0, carry_q = 0.
- Reset values: sum_q = 0, carry_q = 0, err = 0. sum and carry are unaffected by reset.

## Timing
- sum and carry are zero-latency combinational outputs. The RTL contains no # delays.
- The gate depth is at most 3 levels. Outputs must settle well within a 5 ns input hold period.
- sum_q and carry_q have 1-cycle latency: they reflect the a/b/c values sampled at the previous rising edge.
- Reset mid-operation: rst asserted at edge N clears the registers at edge N.
  - The first edge after rst deasserts loads the live result.
- If rst and a data change occur together at one edge, rst wins.

## Configuration
- FULL_ADDER_CHECK_EN, when defined, adds a behavioral cross-check:
  - on every clk edge with rst = 0, compare {carry,sum} against the 2-bit arithmetic sum a+b+c;
  - on any mismatch, set err and hold it at 1 until rst.
  - The check is skipped whenever a, b or c is X/Z.
- When the macro is undefined, the err port and all check logic are absent. The remaining ports and behaviour are identical.

## Structure
- Shared package full_adder_pkg holds:
  - localparam RESULT_W = 2;
  - a typedef for the {carry,sum} result vector;
  - the reset constant RESULT_RST = 2'b00.
- One sub-module, half_adder (ports s, co, x, y), instantiated twice. The OR gate and the registers live in full_adder.

## Test plan
- Exhaustive sweep of a,b,c through 000…111, one vector every 5 ns, ending back at 000:
  - sum/carry match the truth table at each step, e.g. 011 → sum=0, carry=1 and 111 → sum=1, carry=1.
- Hold rst = 1 for 2 cycles with a=b=c=1:
  - sum_q = 0, carry_q = 0 throughout;
  - combinational sum = 1, carry = 1.
- Release rst, then apply 101 at edge N:
  - at edge N+1, sum_q = 0 and carry_q = 1.
- Toggle inputs 000 → 111 mid-cycle, then assert rst at the next edge:
  - the registers read 00 after that edge;
  - the combinational outputs read 11 immediately.
- With FULL_ADDER_CHECK_EN defined, run the full sweep: err stays 0.
- With FULL_ADDER_CHECK_EN defined, force carry to 0 on input 110:
  - err rises to 1 at the next edge and stays 1 until rst.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared types and constants for the full_adder leaf cell.
// Includes the arithmetic reference used by the optional FULL_ADDER_CHECK_EN cross-check.
package full_adder_pkg;

    localparam int RESULT_W = 2;

    // Result vector ordered {carry, sum}
    typedef logic [RESULT_W-1:0] result_t;

    localparam result_t RESULT_RST = 2'b00;

    function automatic result_t arith_sum(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Bundles the operand and result signals of one full_adder cell.
// The master side drives the operands; the slave side is the adder itself.
interface full_adder_if;

    logic a;
    logic b;
    logic c;
    logic sum;
    logic carry;
    logic sum_q;
    logic carry_q;

    modport master (
        output a,
        output b,
        output c,
        input  sum,
        input  carry,
        input  sum_q,
        input  carry_q
    );

    modport slave (
        input  a,
        input  b,
        input  c,
        output sum,
        output carry,
        output sum_q,
        output carry_q
    );

endinterface

// File: rtl/full_adder_half_adder.sv
// Gate-level half adder: s = x ^ y, co = x & y.
// Two instances form the combinational core of full_adder.
module half_adder (
    output wire s,
    output wire co,
    input  wire x,
    input  wire y
);

    xor g_xor (s, x, y);
    and g_and (co, x, y);

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder from two half adders plus registered copies of {carry,sum}.
// Defining FULL_ADDER_CHECK_EN adds a sticky err flag from an arithmetic cross-check.
module full_adder
    import full_adder_pkg::*;
(
    output wire  sum,
    output wire  carry,
    input  wire  a,
    input  wire  b,
    input  wire  c,
    input  wire  clk,
    input  wire  rst,
    output logic sum_q,
    output logic carry_q
`ifdef FULL_ADDER_CHECK_EN
    ,
    output logic err
`endif
);

    wire w_ha0_s;
    wire w_ha0_co;
    wire w_ha1_co;

    result_t r_result;

    half_adder u_ha0 (
        .s  (w_ha0_s),
        .co (w_ha0_co),
        .x  (a),
        .y  (b)
    );

    half_adder u_ha1 (
        .s  (sum),
        .co (w_ha1_co),
        .x  (w_ha0_s),
        .y  (c)
    );

    // Third gate level; the two half-adder carries are never both 1
    or g_or (carry, w_ha0_co, w_ha1_co);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= RESULT_RST;
        end else begin
            r_result <= {carry, sum};
        end
    end

    assign sum_q   = r_result[0];
    assign carry_q = r_result[1];

`ifdef FULL_ADDER_CHECK_EN
    logic r_err;

    // Unknown operands are skipped so X propagation alone never trips the flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (!$isunknown({a, b, c}) &&
                     ({carry, sum} !== arith_sum(a, b, c))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: exhaustive sweep, reset cases, random vectors.
// Expected values come from plain arithmetic on the operands and a per-edge register model.
module tb_full_adder;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [1:0] m_q;

    full_adder_if fa_if ();

`ifdef FULL_ADDER_CHECK_EN
    logic err;
`endif

    full_adder dut (
        .sum     (fa_if.sum),
        .carry   (fa_if.carry),
        .a       (fa_if.a),
        .b       (fa_if.b),
        .c       (fa_if.c),
        .clk     (clk),
        .rst     (rst),
        .sum_q   (fa_if.sum_q),
        .carry_q (fa_if.carry_q)
`ifdef FULL_ADDER_CHECK_EN
        ,
        .err     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] add3(input logic a, input logic b, input logic c);
        int s;
        s = int'(a) + int'(b) + int'(c);
        return 2'(s);
    endfunction

    // Registered-path model: what the flops should hold after each edge
    always @(posedge clk) begin
        m_q <= rst ? 2'b00 : add3(fa_if.a, fa_if.b, fa_if.c);
    end

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_comb"}, {fa_if.carry, fa_if.sum}, add3(fa_if.a, fa_if.b, fa_if.c));
        check({tag, "_regs"}, {fa_if.carry_q, fa_if.sum_q}, m_q);
    endtask

    task automatic set_in(input logic [2:0] v);
        {fa_if.a, fa_if.b, fa_if.c} = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] v;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        set_in(3'b000);

        // Inputs change 2 ns after a negedge and every 5 ns thereafter, never on a rising edge
        @(negedge clk); #2;
        check("reset_regs", {fa_if.carry_q, fa_if.sum_q}, 2'b00);
        rst = 1'b0;

        for (int i = 0; i <= 8; i++) begin
            v = 3'(i % 8);
            set_in(v);
            #1;
            check_all("sweep");
            if (v == 3'b011) check("sweep_011", {fa_if.carry, fa_if.sum}, 2'b10);
            if (v == 3'b111) check("sweep_111", {fa_if.carry, fa_if.sum}, 2'b11);
            #4;
        end

        rst = 1'b1;
        set_in(3'b111);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_hold_regs", {fa_if.carry_q, fa_if.sum_q}, 2'b00);
            check("rst_hold_comb", {fa_if.carry, fa_if.sum}, 2'b11);
            check_all("rst_hold");
        end

        @(negedge clk); #2;
        rst = 1'b0;
        set_in(3'b101);
        @(posedge clk);
        @(posedge clk); #1;
        check("post_rst_101", {fa_if.carry_q, fa_if.sum_q}, 2'b10);
        check_all("post_rst");

        @(negedge clk); #2;
        set_in(3'b000);
        @(posedge clk); #1;
        check("toggle_pre", {fa_if.carry_q, fa_if.sum_q}, 2'b00);
        @(negedge clk);
        set_in(3'b111);
        rst = 1'b1;
        #1;
        check("toggle_comb", {fa_if.carry, fa_if.sum}, 2'b11);
        @(posedge clk); #1;
        check("toggle_rst_regs", {fa_if.carry_q, fa_if.sum_q}, 2'b00);
        check_all("toggle_rst");

        @(negedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            set_in(3'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 9) == 0);
            #1;
            check_all("rand");
            #4;
        end

`ifdef FULL_ADDER_CHECK_EN
        rst = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            set_in(3'(i % 8));
            #5;
        end
        @(posedge clk); #1;
        check("err_sweep", {1'b0, err}, 2'b00);

        @(negedge clk); #2;
        set_in(3'b110);
        force dut.carry = 1'b0;
        @(posedge clk); #1;
        check("err_rise", {1'b0, err}, 2'b01);
        release dut.carry;
        @(posedge clk); #1;
        check("err_sticky", {1'b0, err}, 2'b01);
        rst = 1'b1;
        @(posedge clk); #1;
        check("err_clear", {1'b0, err}, 2'b00);
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
